squash_reset_sequencer: RTL and testbench

Power-up and reset sequencer for the solo_squash game core inside the Caravel user project. It qualifies the management SoC's `gpio_ready` flag and the external `ext_reset_n` pin, holds the game core in reset, and releases the design-pad output enables before it releases reset. It sits between the wrapper pins/logic analyzer and the game core. It also drives the debug pads that mirror its status.

---
 rtl/squash_pkg.sv | 25 ++
 rtl/squash_debounce.sv | 50 +++++
 rtl/squash_reset_sequencer.sv | 123 ++++++++++++
 tb/tb_squash_reset_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/squash_pkg.sv
// Shared types and constants for the solo_squash power-up/reset sequencer.
package squash_pkg;

  typedef enum logic [1:0] {
    StWait,
    StHold,
    StArm,
    StRun
  } squash_state_t;

  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
  localparam int unsigned HOLD_CYCLES_DEF     = 8;
  localparam int unsigned OE_DELAY_DEF        = 4;

  localparam logic [5:0] OEB_ALL_OFF = 6'h3F;

  // Width of a down-counter that must hold values up to max(a, b) - 1.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/squash_debounce.sv
// Synchronizer plus stability debouncer for a bouncy asynchronous pad input.
module squash_debounce
  import squash_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   deb_q, deb_d;
  logic                   din_s;

  assign din_s = sync_q[SYNC_STAGES-1];
  assign dout  = deb_q;

  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (din_s == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      deb_d = ~deb_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

endmodule

// File: rtl/squash_reset_sequencer.sv
// Qualifies gpio_ready / ext_reset_n, holds the game core in reset and enables
// its pads OE_DELAY cycles before releasing reset.
module squash_reset_sequencer
  import squash_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int unsigned OE_DELAY        = OE_DELAY_DEF
) (
  input  logic       wb_clk_i,
  input  logic       rst_n,
  input  logic       wb_rst_i,
  input  logic       gpio_ready,
  input  logic       ext_reset_n,
  output logic       design_reset,
  output logic [5:0] design_oeb,
  output logic [1:0] debug_oeb,
  output logic       debug_design_reset,
  output logic       debug_gpio_ready,
  output logic [7:0] run_count
);

  localparam int unsigned CntW = cnt_width(HOLD_CYCLES, OE_DELAY);
  localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] OeLoad   = CntW'(OE_DELAY - 1);

  logic [SYNC_STAGES-1:0] gpio_sync_q;
  logic                   gpio_s;
  logic                   ext_deb;
  logic                   qual;

  squash_state_t   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            run_inc;

  logic       design_reset_q;
  logic [5:0] design_oeb_q;
  logic [1:0] debug_oeb_q;
  logic [7:0] run_count_q;

  squash_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ext_debounce (
    .clk  (wb_clk_i),
    .rst_n(rst_n),
    .din  (ext_reset_n),
    .dout (ext_deb)
  );

  assign gpio_s = gpio_sync_q[SYNC_STAGES-1];
  assign qual   = gpio_s & ext_deb & ~wb_rst_i;

  // Loss of qualification always wins over a count expiring on the same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run_inc = 1'b0;
    unique case (state_q)
      StWait: begin
        if (qual) begin
          state_d = StHold;
          cnt_d   = HoldLoad;
        end
      end
      StHold: begin
        if (!qual) begin
          state_d = StWait;
        end else if (cnt_q == '0) begin
          state_d = StArm;
          cnt_d   = OeLoad;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StArm: begin
        if (!qual) begin
          state_d = StWait;
        end else if (cnt_q == '0) begin
          state_d = StRun;
          run_inc = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StRun: begin
        if (!qual) state_d = StWait;
      end
      default: state_d = StWait;
    endcase
  end

  // Outputs are registered from the next state so they change on the state edge.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      gpio_sync_q    <= '0;
      state_q        <= StWait;
      cnt_q          <= '0;
      design_reset_q <= 1'b1;
      design_oeb_q   <= OEB_ALL_OFF;
      debug_oeb_q    <= 2'b11;
      run_count_q    <= '0;
    end else begin
      gpio_sync_q    <= {gpio_sync_q[SYNC_STAGES-2:0], gpio_ready};
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      design_reset_q <= (state_d != StRun);
      design_oeb_q   <= (state_d == StWait || state_d == StHold) ? OEB_ALL_OFF : 6'h00;
      // Tracks the value gpio_s takes on this same edge.
      debug_oeb_q    <= gpio_sync_q[SYNC_STAGES-2] ? 2'b00 : 2'b11;
      if (run_inc && run_count_q != 8'hFF) run_count_q <= run_count_q + 8'd1;
    end
  end

  assign design_reset       = design_reset_q;
  assign debug_design_reset = design_reset_q;
  assign design_oeb         = design_oeb_q;
  assign debug_oeb          = debug_oeb_q;
  assign debug_gpio_ready   = gpio_s;
  assign run_count          = run_count_q;

endmodule

// File: tb/tb_squash_reset_sequencer.sv
// Directed self-checking bench for squash_reset_sequencer.
module tb_squash_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic wb_rst_i = 1'b0;
  logic gpio_ready = 1'b0;
  logic ext_reset_n = 1'b1;
  logic design_reset, debug_design_reset, debug_gpio_ready;
  logic [5:0] design_oeb;
  logic [1:0] debug_oeb;
  logic [7:0] run_count;

  logic rst2_n = 1'b1;
  logic gpio2 = 1'b0;
  logic design_reset2, debug_design_reset2, debug_gpio_ready2;
  logic [5:0] design_oeb2;
  logic [1:0] debug_oeb2;
  logic [7:0] run_count2;

  int checks = 0;
  int failures = 0;

  squash_reset_sequencer dut (
    .wb_clk_i          (clk),
    .rst_n             (rst_n),
    .wb_rst_i          (wb_rst_i),
    .gpio_ready        (gpio_ready),
    .ext_reset_n       (ext_reset_n),
    .design_reset      (design_reset),
    .design_oeb        (design_oeb),
    .debug_oeb         (debug_oeb),
    .debug_design_reset(debug_design_reset),
    .debug_gpio_ready  (debug_gpio_ready),
    .run_count         (run_count)
  );

  squash_reset_sequencer #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(1),
    .HOLD_CYCLES    (1),
    .OE_DELAY       (1)
  ) dut_min (
    .wb_clk_i          (clk),
    .rst_n             (rst2_n),
    .wb_rst_i          (wb_rst_i),
    .gpio_ready        (gpio2),
    .ext_reset_n       (ext_reset_n),
    .design_reset      (design_reset2),
    .design_oeb        (design_oeb2),
    .debug_oeb         (debug_oeb2),
    .debug_design_reset(debug_design_reset2),
    .debug_gpio_ready  (debug_gpio_ready2),
    .run_count         (run_count2)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    rst2_n = 1'b0;
    #1;
    checks++; if (design_reset !== 1'b1) begin failures++;
      $display("FAIL reset_design_reset got=%b exp=1", design_reset); end
    checks++; if (design_oeb !== 6'h3F) begin failures++;
      $display("FAIL reset_design_oeb got=%h exp=3f", design_oeb); end
    checks++; if (debug_oeb !== 2'b11) begin failures++;
      $display("FAIL reset_debug_oeb got=%b exp=11", debug_oeb); end
    checks++; if (debug_design_reset !== 1'b1) begin failures++;
      $display("FAIL reset_debug_design_reset got=%b exp=1", debug_design_reset); end
    checks++; if (debug_gpio_ready !== 1'b0) begin failures++;
      $display("FAIL reset_debug_gpio_ready got=%b exp=0", debug_gpio_ready); end
    checks++; if (run_count !== 8'd0) begin failures++;
      $display("FAIL reset_run_count got=%0d exp=0", run_count); end
    tick(3);
    rst_n = 1'b1;
  endtask

  task automatic test_power_up();
    tick(30);
    checks++; if (design_oeb !== 6'h3F || design_reset !== 1'b1) begin failures++;
      $display("FAIL pu_idle got oeb=%h rst=%b exp oeb=3f rst=1", design_oeb, design_reset); end
    gpio_ready = 1'b1;
    tick(1);  // edge e
    checks++; if (debug_gpio_ready !== 1'b0) begin failures++;
      $display("FAIL pu_gpio_sync_e got=%b exp=0", debug_gpio_ready); end
    tick(1);  // e+1
    checks++; if (debug_gpio_ready !== 1'b1 || debug_oeb !== 2'b00) begin failures++;
      $display("FAIL pu_gpio_sync_e1 got rdy=%b doeb=%b exp rdy=1 doeb=00",
               debug_gpio_ready, debug_oeb); end
    tick(8);  // e+9
    checks++; if (design_oeb !== 6'h3F) begin failures++;
      $display("FAIL pu_oeb_e9 got=%h exp=3f", design_oeb); end
    tick(1);  // e+10
    checks++; if (design_oeb !== 6'h00 || design_reset !== 1'b1) begin failures++;
      $display("FAIL pu_arm_e10 got oeb=%h rst=%b exp oeb=00 rst=1", design_oeb, design_reset); end
    tick(3);  // e+13
    checks++; if (design_reset !== 1'b1) begin failures++;
      $display("FAIL pu_reset_e13 got=%b exp=1", design_reset); end
    tick(1);  // e+14
    checks++; if (design_reset !== 1'b0 || debug_design_reset !== 1'b0) begin failures++;
      $display("FAIL pu_run_e14 got rst=%b dbg=%b exp 0 0", design_reset, debug_design_reset); end
    checks++; if (run_count !== 8'd1) begin failures++;
      $display("FAIL pu_run_count got=%0d exp=1", run_count); end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 8; i++) begin
      ext_reset_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      for (int k = 0; k < 5; k++) begin
        tick(1);
        checks++; if (design_reset !== 1'b0) begin failures++;
          $display("FAIL bounce_stay_run seg=%0d cyc=%0d got=%b exp=0", i, k, design_reset); end
      end
    end
    ext_reset_n = 1'b0;  // t0
    tick(18);
    checks++; if (design_reset !== 1'b0) begin failures++;
      $display("FAIL bounce_low_t18 got=%b exp=0", design_reset); end
    tick(1);
    checks++; if (design_reset !== 1'b1 || design_oeb !== 6'h3F) begin failures++;
      $display("FAIL bounce_wait_t19 got rst=%b oeb=%h exp 1 3f", design_reset, design_oeb); end
    tick(6);
    ext_reset_n = 1'b1;  // r
    tick(26);
    checks++; if (design_oeb !== 6'h3F) begin failures++;
      $display("FAIL bounce_rel_oeb_r26 got=%h exp=3f", design_oeb); end
    tick(1);
    checks++; if (design_oeb !== 6'h00) begin failures++;
      $display("FAIL bounce_rel_oeb_r27 got=%h exp=00", design_oeb); end
    tick(3);
    checks++; if (design_reset !== 1'b1) begin failures++;
      $display("FAIL bounce_rel_rst_r30 got=%b exp=1", design_reset); end
    tick(1);
    checks++; if (design_reset !== 1'b0 || run_count !== 8'd2) begin failures++;
      $display("FAIL bounce_rel_run_r31 got rst=%b cnt=%0d exp 0 2", design_reset, run_count); end
  endtask

  task automatic test_abort_arm();
    gpio_ready = 1'b0;
    tick(5);
    checks++; if (design_reset !== 1'b1 || design_oeb !== 6'h3F) begin failures++;
      $display("FAIL abort_idle got rst=%b oeb=%h exp 1 3f", design_reset, design_oeb); end
    gpio_ready = 1'b1;
    tick(11);  // e+10
    checks++; if (design_oeb !== 6'h00) begin failures++;
      $display("FAIL abort_in_arm got=%h exp=00", design_oeb); end
    tick(1);   // e+11
    gpio_ready = 1'b0;
    tick(2);   // e+13
    checks++; if (design_oeb !== 6'h00 || design_reset !== 1'b1) begin failures++;
      $display("FAIL abort_e13 got oeb=%h rst=%b exp 00 1", design_oeb, design_reset); end
    tick(1);   // e+14: count also expires here; abort must win
    checks++; if (design_oeb !== 6'h3F || design_reset !== 1'b1) begin failures++;
      $display("FAIL abort_wait_e14 got oeb=%h rst=%b exp 3f 1", design_oeb, design_reset); end
    checks++; if (run_count !== 8'd2) begin failures++;
      $display("FAIL abort_run_count got=%0d exp=2", run_count); end
  endtask

  task automatic test_simultaneous();
    tick(4);
    gpio_ready = 1'b1;
    tick(10);  // e+9
    wb_rst_i = 1'b1;
    tick(1);   // e+10
    checks++; if (design_oeb !== 6'h3F || design_reset !== 1'b1) begin failures++;
      $display("FAIL simul_wait got oeb=%h rst=%b exp 3f 1", design_oeb, design_reset); end
    wb_rst_i = 1'b0;
    tick(8);   // e+18
    checks++; if (design_oeb !== 6'h3F) begin failures++;
      $display("FAIL simul_rehold_e18 got=%h exp=3f", design_oeb); end
    tick(1);   // e+19
    checks++; if (design_oeb !== 6'h00) begin failures++;
      $display("FAIL simul_arm_e19 got=%h exp=00", design_oeb); end
    tick(4);   // e+23
    checks++; if (design_reset !== 1'b0 || run_count !== 8'd3) begin failures++;
      $display("FAIL simul_run_e23 got rst=%b cnt=%0d exp 0 3", design_reset, run_count); end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (design_reset !== 1'b1 || debug_design_reset !== 1'b1) begin failures++;
      $display("FAIL async_rst got rst=%b dbg=%b exp 1 1", design_reset, debug_design_reset); end
    checks++; if (design_oeb !== 6'h3F || debug_oeb !== 2'b11) begin failures++;
      $display("FAIL async_oeb got oeb=%h doeb=%b exp 3f 11", design_oeb, debug_oeb); end
    checks++; if (run_count !== 8'd0 || debug_gpio_ready !== 1'b0) begin failures++;
      $display("FAIL async_cnt got cnt=%0d rdy=%b exp 0 0", run_count, debug_gpio_ready); end
    #1 rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_saturation();
    logic [7:0] exp8;
    rst2_n = 1'b1;
    tick(6);
    for (int i = 0; i < 260; i++) begin
      gpio2 = 1'b1;
      tick(6);
      gpio2 = 1'b0;
      tick(4);
      exp8 = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
      checks++; if (run_count2 !== exp8) begin failures++;
        $display("FAIL sat_count iter=%0d got=%0d exp=%0d", i, run_count2, exp8); end
    end
    checks++; if (design_reset2 !== 1'b1 || design_oeb2 !== 6'h3F) begin failures++;
      $display("FAIL sat_end_wait got rst=%b oeb=%h exp 1 3f", design_reset2, design_oeb2); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_power_up();
    test_bounce();
    test_abort_arm();
    test_simultaneous();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
